// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the MEM-stage data memory responder.
// Holds the access FSM state encoding and the address legality check.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Word-aligned and inside [base, base + 4*depth); 33-bit math keeps addr < base from wrapping in.
  function automatic logic addr_legal(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input int unsigned depth);
    logic [32:0] off;
    logic [32:0] lim;
    off = {1'b0, addr} - {1'b0, base};
    lim = 33'(depth) << 2;
    return (addr[1:0] == 2'b00) && (off < lim);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage for the data memory: synchronous write, asynchronous read.
// Contents survive reset.
module dmem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 8,
  parameter     INIT_FILE   = ""
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder for the pipelined MIPS MEM stage: fixed-latency access
// sequencing, stall/ready handshake to the hazard unit and a sticky address fault flag.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no access in flight; a legal request raises MemStall at once
//   WAIT  | counting down the remaining stall cycles
//   RESP  | completion cycle: MemReady, load data out, store commits at edge
module data_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          LATENCY     = 2,
  parameter              INIT_FILE   = ""
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] AddrM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadData,
  output logic        MemStall,
  output logic        MemReady,
  output logic        AddrFault
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY > 1) ? (LATENCY - 1) : 0);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          wr_q, wr_d;
  logic          fault_q, fault_d;

  logic          req_any, req_legal;
  logic [AW-1:0] idx;
  logic [AW-1:0] arr_raddr, arr_waddr;
  logic [31:0]   arr_wdata, arr_rdata;
  logic          arr_we;
  logic          stall, ready;
  logic [31:0]   rd_out;

  always_comb begin
    req_any   = MemReadM | MemWriteM;
    req_legal = req_any & ~(MemReadM & MemWriteM) & addr_legal(AddrM, BASE_ADDR, DEPTH_WORDS);
    idx       = AW'((AddrM - BASE_ADDR) >> 2);

    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    wdata_d   = wdata_q;
    idx_d     = idx_q;
    wr_d      = wr_q;
    fault_d   = fault_q;
    arr_raddr = idx;
    arr_waddr = idx;
    arr_wdata = WriteDataM;
    arr_we    = 1'b0;
    stall     = 1'b0;
    ready     = 1'b0;
    rd_out    = '0;

    if (LATENCY == 0) begin
      arr_we  = req_legal & MemWriteM;
      ready   = req_legal;
      rd_out  = (req_legal & MemReadM) ? arr_rdata : '0;
      fault_d = fault_q | (req_any & ~req_legal);
    end else begin
      arr_raddr = (state_q == IDLE) ? idx : idx_q;
      arr_waddr = idx_q;
      arr_wdata = wdata_q;
      case (state_q)
        IDLE: begin
          fault_d = fault_q | (req_any & ~req_legal);
          if (req_legal) begin
            stall   = 1'b1;
            idx_d   = idx;
            wr_d    = MemWriteM;
            wdata_d = WriteDataM;
            if (LATENCY > 1) begin
              state_d = WAIT;
              cnt_d   = CNT_INIT;
            end else begin
              state_d = RESP;
              rdata_d = arr_rdata;
            end
          end
        end
        WAIT: begin
          stall = 1'b1;
          if (cnt_q == CW'(1)) begin
            state_d = RESP;
            cnt_d   = '0;
            rdata_d = arr_rdata;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        RESP: begin
          ready   = 1'b1;
          arr_we  = wr_q;
          rd_out  = wr_q ? '0 : rdata_q;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    // Reset abandons any access: nothing visible, no pending store committed.
    if (RST) begin
      stall  = 1'b0;
      ready  = 1'b0;
      rd_out = '0;
      arr_we = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      wdata_q <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      wdata_q <= wdata_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      fault_q <= fault_d;
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW),
    .INIT_FILE   (INIT_FILE)
  ) u_dmem_array (
    .clk   (CLK),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .raddr (arr_raddr),
    .rdata (arr_rdata)
  );

  assign ReadData  = rd_out;
  assign MemStall  = stall;
  assign MemReady  = ready;
  assign AddrFault = fault_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: four instances at LATENCY 0..3 exercised
// with hand-computed cycle-by-cycle expectations.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        rst0, rd0, wr0, st0, rdy0, flt0;
  logic [31:0] a0, wd0, rdat0;
  logic        rst1, rd1, wr1, st1, rdy1, flt1;
  logic [31:0] a1, wd1, rdat1;
  logic        rst2, rd2, wr2, st2, rdy2, flt2;
  logic [31:0] a2, wd2, rdat2;
  logic        rst3, rd3, wr3, st3, rdy3, flt3;
  logic [31:0] a3, wd3, rdat3;

  logic [31:0] pat [4];

  data_mem_responder #(.LATENCY(0)) u_lat0 (
    .CLK(clk), .RST(rst0), .MemReadM(rd0), .MemWriteM(wr0), .AddrM(a0), .WriteDataM(wd0),
    .ReadData(rdat0), .MemStall(st0), .MemReady(rdy0), .AddrFault(flt0));
  data_mem_responder #(.LATENCY(1)) u_lat1 (
    .CLK(clk), .RST(rst1), .MemReadM(rd1), .MemWriteM(wr1), .AddrM(a1), .WriteDataM(wd1),
    .ReadData(rdat1), .MemStall(st1), .MemReady(rdy1), .AddrFault(flt1));
  data_mem_responder #(.LATENCY(2)) u_lat2 (
    .CLK(clk), .RST(rst2), .MemReadM(rd2), .MemWriteM(wr2), .AddrM(a2), .WriteDataM(wd2),
    .ReadData(rdat2), .MemStall(st2), .MemReady(rdy2), .AddrFault(flt2));
  data_mem_responder #(.LATENCY(3)) u_lat3 (
    .CLK(clk), .RST(rst3), .MemReadM(rd3), .MemWriteM(wr3), .AddrM(a3), .WriteDataM(wd3),
    .ReadData(rdat3), .MemStall(st3), .MemReady(rdy3), .AddrFault(flt3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    pat[0] = 32'h0BAD_F00D;
    pat[1] = 32'h1357_9BDF;
    pat[2] = 32'hFFFF_0000;
    pat[3] = 32'h0000_0001;

    rst0 = 1'b1; rd0 = 1'b0; wr0 = 1'b0; a0 = '0; wd0 = '0;
    rst1 = 1'b1; rd1 = 1'b0; wr1 = 1'b0; a1 = '0; wd1 = '0;
    rst2 = 1'b1; rd2 = 1'b0; wr2 = 1'b0; a2 = '0; wd2 = '0;
    rst3 = 1'b1; rd3 = 1'b0; wr3 = 1'b0; a3 = '0; wd3 = '0;

    // reset for two cycles
    tick; tick;
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
    #1;
    chk("rst_l2_stall", st2, 0);
    chk("rst_l2_ready", rdy2, 0);
    chk("rst_l2_rdata", rdat2, 0);
    chk("rst_l2_fault", flt2, 0);
    chk("rst_l0_ready", rdy0, 0);
    chk("rst_l0_rdata", rdat0, 0);
    chk("rst_l0_fault", flt0, 0);
    chk("rst_l3_stall", st3, 0);
    chk("rst_l3_fault", flt3, 0);

    // LATENCY=2 store then load at 0x10
    wr2 = 1'b1; a2 = 32'h10; wd2 = 32'hDEAD_BEEF;
    #1;
    chk("l2_wr_c1_stall", st2, 1);
    chk("l2_wr_c1_ready", rdy2, 0);
    tick;
    chk("l2_wr_c2_stall", st2, 1);
    chk("l2_wr_c2_ready", rdy2, 0);
    tick;
    chk("l2_wr_c3_stall", st2, 0);
    chk("l2_wr_c3_ready", rdy2, 1);
    tick;
    wr2 = 1'b0; rd2 = 1'b1;
    #1;
    chk("l2_rd_c1_stall", st2, 1);
    chk("l2_rd_c1_rdata", rdat2, 0);
    tick;
    chk("l2_rd_c2_stall", st2, 1);
    tick;
    chk("l2_rd_c3_stall", st2, 0);
    chk("l2_rd_c3_ready", rdy2, 1);
    chk("l2_rd_c3_rdata", rdat2, 32'hDEAD_BEEF);
    tick;
    rd2 = 1'b0; a2 = '0;
    #1;
    chk("l2_idle_rdata", rdat2, 0);
    chk("l2_idle_ready", rdy2, 0);
    chk("l2_idle_stall", st2, 0);

    // LATENCY=0 store then load at 0x3FC (last word)
    wr0 = 1'b1; a0 = 32'h3FC; wd0 = 32'h1234_5678;
    #1;
    chk("l0_wr_stall", st0, 0);
    chk("l0_wr_ready", rdy0, 1);
    tick;
    wr0 = 1'b0; rd0 = 1'b1;
    #1;
    chk("l0_rd_stall", st0, 0);
    chk("l0_rd_ready", rdy0, 1);
    chk("l0_rd_rdata", rdat0, 32'h1234_5678);
    tick;
    rd0 = 1'b0;
    #1;
    chk("l0_idle_rdata", rdat0, 0);
    chk("l0_idle_ready", rdy0, 0);

    // LATENCY=0 simultaneous read and write is a fault
    rd0 = 1'b1; wr0 = 1'b1; a0 = 32'h8;
    #1;
    chk("l0_rw_ready", rdy0, 0);
    chk("l0_rw_rdata", rdat0, 0);
    tick;
    rd0 = 1'b0; wr0 = 1'b0;
    #1;
    chk("l0_rw_fault", flt0, 1);

    // LATENCY=2 misaligned and out-of-range loads
    chk("l2_pre_fault", flt2, 0);
    rd2 = 1'b1; a2 = 32'h13;
    #1;
    chk("l2_mis_stall", st2, 0);
    chk("l2_mis_rdata", rdat2, 0);
    chk("l2_mis_ready", rdy2, 0);
    tick;
    a2 = 32'h400;
    #1;
    chk("l2_mis_fault", flt2, 1);
    chk("l2_oor_stall", st2, 0);
    chk("l2_oor_rdata", rdat2, 0);
    chk("l2_oor_ready", rdy2, 0);
    tick;
    rd2 = 1'b0; a2 = '0;
    #1;
    chk("l2_oor_fault", flt2, 1);
    tick; tick;
    chk("l2_fault_sticky", flt2, 1);
    rst2 = 1'b1;
    tick;
    rst2 = 1'b0;
    #1;
    chk("l2_fault_cleared", flt2, 0);

    // LATENCY=3: known value, then store aborted by reset, then load
    wr3 = 1'b1; a3 = 32'h20; wd3 = 32'h1111_1111;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("l3_init_stall", st3, 1);
      tick;
    end
    chk("l3_init_done_stall", st3, 0);
    chk("l3_init_done_ready", rdy3, 1);
    tick;
    wd3 = 32'hA5A5_A5A5;
    #1;
    chk("l3_abort_c1_stall", st3, 1);
    tick;
    chk("l3_abort_c2_stall", st3, 1);
    rst3 = 1'b1;
    tick;
    rst3 = 1'b0; wr3 = 1'b0; a3 = '0;
    #1;
    chk("l3_post_rst_stall", st3, 0);
    chk("l3_post_rst_ready", rdy3, 0);
    tick; tick;
    chk("l3_no_late_ready", rdy3, 0);
    rd3 = 1'b1; a3 = 32'h20;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("l3_rd_stall", st3, 1);
      tick;
    end
    chk("l3_rd_ready", rdy3, 1);
    chk("l3_rd_old_data", rdat3, 32'h1111_1111);
    tick;
    rd3 = 1'b0;
    #1;
    chk("l3_idle_rdata", rdat3, 0);

    // LATENCY=1 back-to-back store/load pairs to one word
    a1 = 32'h40;
    for (int i = 0; i < 4; i++) begin
      wr1 = 1'b1; rd1 = 1'b0; wd1 = pat[i];
      #1;
      chk("l1_wr_stall", st1, 1);
      chk("l1_wr_ready_early", rdy1, 0);
      tick;
      chk("l1_wr_done_stall", st1, 0);
      chk("l1_wr_ready", rdy1, 1);
      tick;
      wr1 = 1'b0; rd1 = 1'b1;
      #1;
      chk("l1_rd_stall", st1, 1);
      tick;
      chk("l1_rd_done_stall", st1, 0);
      chk("l1_rd_ready", rdy1, 1);
      chk("l1_rd_data", rdat1, pat[i]);
      tick;
    end
    rd1 = 1'b0;
    #1;
    chk("l1_final_stall", st1, 0);
    chk("l1_final_fault", flt1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
